// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle FETCH/DECODE/EXECUTE/WRITEBACK control FSM for the 8-bit CPU
module multicycle_control #(
    parameter int   MEM_RD_WAIT = 0,
    parameter logic ZF_RESET    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       acc_write,
    output logic       acc_src,
    output logic [2:0] alu_op,
    output logic       z_flag,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        IR_LOAD = 4'd2,
        DECODE  = 4'd3,
        MEM_RD  = 4'd4,
        ALU_WB  = 4'd5,
        LOAD_WB = 4'd6,
        STORE   = 4'd7,
        BRANCH  = 4'd8
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(MEM_RD_WAIT);

    state_t     cur;
    state_t     nxt;
    logic [1:0] cnt;

    assign state = cur;

    always_comb begin
        nxt = IDLE;
        case (cur)
            IDLE:    nxt = run ? FETCH : IDLE;
            FETCH:   nxt = (cnt == WAIT_LAST) ? IR_LOAD : FETCH;
            IR_LOAD: nxt = DECODE;
            DECODE: begin
                if (!opcode[2] || opcode == 3'b100)
                    nxt = MEM_RD;
                else if (opcode == 3'b101)
                    nxt = STORE;
                else
                    nxt = BRANCH;
            end
            MEM_RD:  nxt = (cnt != WAIT_LAST) ? MEM_RD : (opcode[2] ? LOAD_WB : ALU_WB);
            ALU_WB, LOAD_WB, STORE, BRANCH: nxt = run ? FETCH : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= IDLE;
            cnt        <= 2'd0;
            z_flag     <= ZF_RESET;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            addr_sel   <= 1'b0;
            ir_write   <= 1'b0;
            pc_write   <= 1'b0;
            pc_src     <= 1'b0;
            acc_write  <= 1'b0;
            acc_src    <= 1'b0;
            alu_op     <= 3'b000;
            instr_done <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt == cur && (cur == FETCH || cur == MEM_RD))
                cnt <= cnt + 2'd1;
            else
                cnt <= 2'd0;
            if (cur == ALU_WB)
                z_flag <= zero;
            mem_read   <= (nxt == FETCH) || (nxt == MEM_RD);
            mem_write  <= (nxt == STORE);
            addr_sel   <= (nxt == MEM_RD) || (nxt == STORE);
            ir_write   <= (nxt == IR_LOAD);
            // z_flag cannot change while moving DECODE -> BRANCH, so its current value is the one JZ tests.
            pc_write   <= (nxt == IR_LOAD) ||
                          (nxt == BRANCH && (opcode == 3'b110 || (opcode == 3'b111 && z_flag)));
            pc_src     <= (nxt == BRANCH);
            acc_write  <= (nxt == ALU_WB) || (nxt == LOAD_WB);
            acc_src    <= (nxt == LOAD_WB);
            alu_op     <= (nxt == ALU_WB) ? {1'b0, opcode[1:0]} : 3'b000;
            instr_done <= (nxt == ALU_WB) || (nxt == LOAD_WB) || (nxt == STORE) || (nxt == BRANCH);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control at MEM_RD_WAIT 0 and 2
module tb_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, run0, zero0, rst1, run1, zero1;
    logic [2:0] op0, op1;
    logic       mr0, mw0, as0, irw0, pcw0, pcs0, accw0, accs0, zf0, done0;
    logic       mr1, mw1, as1, irw1, pcw1, pcs1, accw1, accs1, zf1, done1;
    logic [2:0] alu0, alu1;
    logic [3:0] st0, st1;

    multicycle_control dut0 (
        .clk(clk), .rst(rst0), .run(run0), .opcode(op0), .zero(zero0),
        .mem_read(mr0), .mem_write(mw0), .addr_sel(as0), .ir_write(irw0),
        .pc_write(pcw0), .pc_src(pcs0), .acc_write(accw0), .acc_src(accs0),
        .alu_op(alu0), .z_flag(zf0), .instr_done(done0), .state(st0)
    );

    multicycle_control #(.MEM_RD_WAIT(2)) dut2 (
        .clk(clk), .rst(rst1), .run(run1), .opcode(op1), .zero(zero1),
        .mem_read(mr1), .mem_write(mw1), .addr_sel(as1), .ir_write(irw1),
        .pc_write(pcw1), .pc_src(pcs1), .acc_write(accw1), .acc_src(accs1),
        .alu_op(alu1), .z_flag(zf1), .instr_done(done1), .state(st1)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic        zm0, zm1;
    logic [16:0] act0, act1;

    assign act0 = {st0, mr0, mw0, as0, irw0, pcw0, pcs0, accw0, accs0, alu0, zf0, done0};
    assign act1 = {st1, mr1, mw1, as1, irw1, pcw1, pcs1, accw1, accs1, alu1, zf1, done1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) check($sformatf("w0 cyc%0d", cyc), act0, q0.pop_front());
        if (q1.size() > 0) check($sformatf("w2 cyc%0d", cyc), act1, q1.pop_front());
    end

    // record layout: state, mem_read mem_write addr_sel ir_write pc_write pc_src acc_write acc_src, alu_op, z_flag, instr_done
    function automatic logic [16:0] rec(input logic [3:0] st, input logic [7:0] strb,
                                        input logic [2:0] alu, input logic z, input logic done);
        return {st, strb, alu, z, done};
    endfunction

    task automatic push(input int inst, input logic [16:0] r);
        if (inst == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    task automatic wait_empty(input int inst);
        int left;
        left = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            left = (inst == 0) ? q0.size() : q1.size();
            if (left == 0) break;
        end
        if (left != 0) begin
            check($sformatf("timeout w%0d", inst), 17'(left), 17'd0);
            if (inst == 0) q0.delete();
            else q1.delete();
        end
    endtask

    task automatic set_inputs(input int inst, input logic r, input logic [2:0] op, input logic z);
        if (inst == 0) begin run0 = r; op0 = op; zero0 = z; end
        else begin run1 = r; op1 = op; zero1 = z; end
    endtask

    // Push the expected trace of one instruction, start it, and wait until the trace is consumed.
    task automatic issue(input int inst, input logic [2:0] op, input logic z, input int w,
                         input logic run_after, input logic partial);
        logic zf;
        zf = (inst == 0) ? zm0 : zm1;
        if (inst == 0) run0 = 1'b1;
        else run1 = 1'b1;
        for (int i = 0; i <= w; i++) push(inst, rec(4'd1, 8'b1000_0000, 3'b000, zf, 1'b0));
        push(inst, rec(4'd2, 8'b0001_1000, 3'b000, zf, 1'b0));
        push(inst, rec(4'd3, 8'b0000_0000, 3'b000, zf, 1'b0));
        if (partial) begin
            push(inst, rec(4'd4, 8'b1010_0000, 3'b000, zf, 1'b0));
        end else begin
            if (op <= 3'd4)
                for (int i = 0; i <= w; i++) push(inst, rec(4'd4, 8'b1010_0000, 3'b000, zf, 1'b0));
            if (op < 3'd4) begin
                push(inst, rec(4'd5, 8'b0000_0010, {1'b0, op[1:0]}, zf, 1'b1));
                zf = z;
            end else if (op == 3'd4)
                push(inst, rec(4'd6, 8'b0000_0011, 3'b000, zf, 1'b1));
            else if (op == 3'd5)
                push(inst, rec(4'd7, 8'b0110_0000, 3'b000, zf, 1'b1));
            else
                push(inst, rec(4'd8, {4'b0000, (op == 3'd6) || zf, 3'b100}, 3'b000, zf, 1'b1));
            if (!run_after) push(inst, rec(4'd0, 8'd0, 3'b000, zf, 1'b0));
        end
        if (inst == 0) zm0 = zf;
        else zm1 = zf;
        @(posedge clk);
        #1;
        set_inputs(inst, run_after, op, z);
        wait_empty(inst);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] rop;
        logic       rz;
        rst0 = 1'b1; rst1 = 1'b1;
        set_inputs(0, 1'b0, 3'b000, 1'b0);
        set_inputs(1, 1'b0, 3'b000, 1'b0);
        zm0 = 1'b0; zm1 = 1'b0;
        push(0, rec(4'd0, 8'd0, 3'b000, 1'b0, 1'b0));
        push(1, rec(4'd0, 8'd0, 3'b000, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(0, rec(4'd0, 8'd0, 3'b000, 1'b0, 1'b0));
            push(1, rec(4'd0, 8'd0, 3'b000, 1'b0, 1'b0));
        end
        wait_empty(0);
        wait_empty(1);

        issue(0, 3'b000, 1'b1, 0, 1'b1, 1'b0);   // ADD, z -> 1
        issue(0, 3'b001, 1'b0, 0, 1'b1, 1'b0);   // SUB, z -> 0
        issue(0, 3'b100, 1'b1, 0, 1'b1, 1'b0);   // LDA, z unchanged
        issue(0, 3'b101, 1'b0, 0, 1'b1, 1'b0);   // STA
        issue(0, 3'b111, 1'b0, 0, 1'b1, 1'b0);   // JZ not taken
        issue(0, 3'b011, 1'b1, 0, 1'b1, 1'b0);   // OR, z -> 1
        issue(0, 3'b111, 1'b0, 0, 1'b1, 1'b0);   // JZ taken
        issue(0, 3'b110, 1'b1, 0, 1'b1, 1'b0);   // JMP
        issue(0, 3'b010, 1'b0, 0, 1'b1, 1'b0);   // AND, z -> 0
        issue(0, 3'b110, 1'b0, 0, 1'b0, 1'b0);   // JMP with z=0, then IDLE
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            rz  = 1'($urandom_range(0, 1));
            issue(0, rop, rz, 0, (i % 3) != 2, 1'b0);
        end

        issue(1, 3'b000, 1'b1, 2, 1'b1, 1'b0);   // ADD with wait states, z -> 1
        issue(1, 3'b000, 1'b0, 2, 1'b1, 1'b1);   // abandoned in first MEM_RD cycle
        rst1 = 1'b1;
        run1 = 1'b1;
        zm1  = 1'b0;
        push(1, rec(4'd0, 8'd0, 3'b000, 1'b0, 1'b0));
        wait_empty(1);
        rst1 = 1'b0;
        run1 = 1'b0;
        push(1, rec(4'd0, 8'd0, 3'b000, 1'b0, 1'b0));
        push(1, rec(4'd0, 8'd0, 3'b000, 1'b0, 1'b0));
        wait_empty(1);
        issue(1, 3'b100, 1'b1, 2, 1'b0, 1'b0);   // LDA with wait states, then IDLE

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
